// File: rtl/lift_ctrl_scan.sv
// SCAN-order lift controller: per-floor call bitmap, timed travel and door dwell.
// Optional emergency stop (estop input, HALT state) enabled by LIFT_ESTOP_EN.
module lift_ctrl_scan #(
    parameter int FLOORS     = 6,
    parameter int FLOOR_W    = 3,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
`ifdef LIFT_ESTOP_EN
    input  logic               estop,
`endif
    output logic [1:0]         motor,
    output logic               door_open,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic [FLOORS-1:0]  pending,
    output logic               busy
);
    localparam int MAXC = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYC - 1);
    localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYC - 1);
    localparam logic [TW-1:0] ONE_T = TW'(1);
    localparam logic [FLOOR_W-1:0] ONE_F = FLOOR_W'(1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DN,
        DOOR
`ifdef LIFT_ESTOP_EN
        , HALT
`endif
    } state_t;

    state_t             state_q, state_d, eff;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [FLOOR_W-1:0] floor_d;
    logic               dir_up_q, dir_up_d;
    logic [FLOORS-1:0]  here_mask, req_mask, pend_d;
    logic               any_above, any_below, here, req_here;
    logic               clr_here, block;

    // HALT resumes by running the saved state's logic on the release edge
`ifdef LIFT_ESTOP_EN
    state_t saved_q;
    assign eff = (state_q == HALT) ? saved_q : state_q;
    assign block = (eff == DOOR) && !estop;
`else
    assign eff = state_q;
    assign block = (eff == DOOR);
`endif

    always_comb begin
        here_mask = '0;
        req_mask  = '0;
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            here_mask[i] = (FLOOR_W'(i) == cur_floor);
            req_mask[i]  = req_valid && (FLOOR_W'(i) == req_floor);
            if (FLOOR_W'(i) > cur_floor) any_above = any_above | pending[i];
            if (FLOOR_W'(i) < cur_floor) any_below = any_below | pending[i];
        end
        here     = |(pending & here_mask);
        req_here = |(req_mask & here_mask);
    end

    always_comb begin
        state_d  = eff;
        tmr_d    = tmr_q;
        floor_d  = cur_floor;
        dir_up_d = dir_up_q;
        clr_here = 1'b0;
        unique case (eff)
            IDLE: begin
                if (here) begin
                    state_d  = DOOR;
                    tmr_d    = '0;
                    clr_here = 1'b1;
                end else if (dir_up_q && any_above) begin
                    state_d = MOVE_UP;
                end else if (!dir_up_q && any_below) begin
                    state_d = MOVE_DN;
                end else if (any_above) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (any_below) begin
                    state_d  = MOVE_DN;
                    dir_up_d = 1'b0;
                end
            end
            MOVE_UP, MOVE_DN: begin
                if (tmr_q == TRAVEL_LAST) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                    floor_d = (eff == MOVE_UP) ? cur_floor + ONE_F
                                               : cur_floor - ONE_F;
                end else begin
                    tmr_d = tmr_q + ONE_T;
                end
            end
            DOOR: begin
                if (req_here) begin
                    tmr_d = '0;
                end else if (tmr_q == DOOR_LAST) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + ONE_T;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef LIFT_ESTOP_EN
        if (estop) begin
            state_d  = HALT;
            tmr_d    = tmr_q;
            floor_d  = cur_floor;
            dir_up_d = dir_up_q;
            clr_here = 1'b0;
        end
`endif
        pend_d = (pending | (req_mask & ~(here_mask & {FLOORS{block}})))
                 & ~(here_mask & {FLOORS{clr_here}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            cur_floor <= '0;
            dir_up_q  <= 1'b1;
            pending   <= '0;
            motor     <= 2'b00;
            door_open <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            cur_floor <= floor_d;
            dir_up_q  <= dir_up_d;
            pending   <= pend_d;
            motor     <= (state_d == MOVE_UP) ? 2'b01 :
                         (state_d == MOVE_DN) ? 2'b10 : 2'b00;
            door_open <= (state_d == DOOR);
            busy      <= (state_d != IDLE) || (|pend_d);
        end
    end

`ifdef LIFT_ESTOP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) saved_q <= IDLE;
        else if (estop) saved_q <= eff;
    end
`endif

    a_up_bound: assert property (@(posedge clk) disable iff (rst)
        eff == MOVE_UP |-> cur_floor < TOP_FLOOR);
    a_dn_bound: assert property (@(posedge clk) disable iff (rst)
        eff == MOVE_DN |-> cur_floor != '0);
    a_range: assert property (@(posedge clk) disable iff (rst)
        cur_floor <= TOP_FLOOR);
endmodule

// File: tb/tb_lift_ctrl_scan.sv
// Self-checking bench for lift_ctrl_scan: vector table, corner sequences,
// and randomized calls against a countdown-based SCAN reference model.
`timescale 1ns/1ps
module tb_lift_ctrl_scan;
    localparam int F  = 6;
    localparam int W  = 3;
    localparam int TC = 4;
    localparam int DC = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [W-1:0] req_floor;
`ifdef LIFT_ESTOP_EN
    logic         estop;
`endif
    logic [1:0]   motor;
    logic         door_open;
    logic [W-1:0] cur_floor;
    logic [F-1:0] pending;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lift_ctrl_scan #(
        .FLOORS(F), .FLOOR_W(W), .TRAVEL_CYC(TC), .DOOR_CYC(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_floor(req_floor),
`ifdef LIFT_ESTOP_EN
        .estop(estop),
`endif
        .motor(motor),
        .door_open(door_open),
        .cur_floor(cur_floor),
        .pending(pending),
        .busy(busy)
    );

    typedef struct {
        bit rv;
        int rf;
        int mot;
        bit door;
        int flr;
        int pend;
        bit bsy;
    } vec_t;

    vec_t tbl[$];
    int   stops[$];

    function automatic void add(bit rv, int rf, int mot, bit dr,
                                int fl, int pd, bit bs);
        vec_t v;
        v.rv = rv; v.rf = rf; v.mot = mot; v.door = dr;
        v.flr = fl; v.pend = pd; v.bsy = bs;
        tbl.push_back(v);
    endfunction

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic int stop_at(int i);
        return (i < stops.size()) ? stops[i] : -1;
    endfunction

    // Reference model: remaining-cycle countdowns and a SCAN target choice.
    int         m_floor, m_dir, m_step, m_move, m_door;
    bit [F-1:0] m_pend;

    function automatic void model_reset();
        m_floor = 0; m_dir = 1; m_step = 0;
        m_move = 0; m_door = 0; m_pend = '0;
    endfunction

    function automatic void model_step(bit rv, int rf);
        bit [F-1:0] np;
        int above, below, want;
        np = m_pend;
        if (rv && rf < F && !(m_door > 0 && rf == m_floor)) np[rf] = 1'b1;
        if (m_door > 0) begin
            if (rv && rf == m_floor) m_door = DC;
            else m_door--;
        end else if (m_move > 0) begin
            m_move--;
            if (m_move == 0) m_floor += m_step;
        end else if (m_pend[m_floor]) begin
            m_door = DC;
            np[m_floor] = 1'b0;
        end else begin
            above = 0; below = 0; want = 0;
            for (int i = 0; i < F; i++) begin
                if (m_pend[i] && i > m_floor) above++;
                if (m_pend[i] && i < m_floor) below++;
            end
            if (above > 0 && (m_dir > 0 || below == 0)) want = 1;
            else if (below > 0) want = -1;
            if (want != 0) begin
                m_dir = want; m_step = want; m_move = TC;
            end
        end
        m_pend = np;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit rv, int rf);
        req_valid = rv;
        req_floor = W'(rf);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0);
`ifdef LIFT_ESTOP_EN
        estop = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int down_at;
        int issued;
        bit prev_door;
        bit rv;
        int rf;
        int exp_mot;

        // test 1: call at current floor, then out-of-range calls
        add(1, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        add(1, 7, 0, 0, 0, 0, 0);
        add(1, 6, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // test 2: floor 0 -> 3
        add(1, 3, 0, 0, 0, 8, 1);
        for (int j = 2; j <= 16; j++)
            add(0, 0, ((j - 1) % 5 == 0) ? 0 : 1, 0, (j - 1) / 5, 8, 1);
        for (int j = 17; j <= 19; j++) add(0, 0, 0, 1, 3, 0, 1);
        add(0, 0, 0, 0, 3, 0, 0);
        // door reopen in the 2nd door cycle
        add(1, 3, 0, 0, 3, 8, 1);
        add(0, 0, 0, 1, 3, 0, 1);
        add(0, 0, 0, 1, 3, 0, 1);
        add(1, 3, 0, 1, 3, 0, 1);
        add(0, 0, 0, 1, 3, 0, 1);
        add(0, 0, 0, 1, 3, 0, 1);
        add(0, 0, 0, 0, 3, 0, 0);
        // same-floor call on the door-entry edge: clear wins
        add(1, 3, 0, 0, 3, 8, 1);
        add(1, 3, 0, 1, 3, 0, 1);
        add(0, 0, 0, 1, 3, 0, 1);
        add(0, 0, 0, 1, 3, 0, 1);
        add(0, 0, 0, 0, 3, 0, 0);

        do_reset();
        check("rst_motor", motor, 0);
        check("rst_door", door_open, 0);
        check("rst_floor", cur_floor, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rv, tbl[i].rf);
            tick();
            drive(0, 0);
            check($sformatf("vec%0d_motor", i), motor, tbl[i].mot);
            check($sformatf("vec%0d_door", i), door_open, tbl[i].door);
            check($sformatf("vec%0d_floor", i), cur_floor, tbl[i].flr);
            check($sformatf("vec%0d_pending", i), pending, tbl[i].pend);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
        end

        // SCAN order: at floor 2 heading up, calls at 1 and 5
        do_reset();
        stops.delete();
        down_at = -1;
        prev_door = 1'b0;
        issued = 0;
        drive(1, 2);
        for (int c = 0; c < 200 && stops.size() < 3; c++) begin
            tick();
            drive(0, 0);
            if (door_open && !prev_door) stops.push_back(int'(cur_floor));
            prev_door = door_open;
            if (motor == 2'b10 && down_at < 0) down_at = stops.size();
            if (issued == 0 && cur_floor == 2) begin
                drive(1, 1);
                issued = 1;
            end else if (issued == 1) begin
                drive(1, 5);
                issued = 2;
            end
        end
        check("scan_nstops", stops.size(), 3);
        check("scan_stop0", stop_at(0), 2);
        check("scan_stop1", stop_at(1), 5);
        check("scan_stop2", stop_at(2), 1);
        check("scan_down_after", down_at, 2);

        // async reset between floors 2 and 3
        do_reset();
        drive(1, 3);
        tick();
        drive(1, 5);
        tick();
        drive(0, 0);
        n = 0;
        while (!(cur_floor == 2 && motor == 2'b01) && n < 60) begin
            tick();
            n++;
        end
        check("rstmv_reach", int'(cur_floor == 2 && motor == 2'b01), 1);
        #2 rst = 1'b1;
        #1;
        check("rstmv_motor", motor, 0);
        check("rstmv_floor", cur_floor, 0);
        check("rstmv_pending", pending, 0);
        check("rstmv_door", door_open, 0);
        check("rstmv_busy", busy, 0);
        tick();
        rst = 1'b0;

`ifdef LIFT_ESTOP_EN
        do_reset();
        drive(1, 3);
        tick();
        drive(0, 0);
        n = 0;
        while (cur_floor != 1 && n < 50) begin
            tick();
            n++;
        end
        check("es_reach1", cur_floor, 1);
        tick();
        tick();
        estop = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(1, 4);
            tick();
            drive(0, 0);
            check("es_motor", motor, 0);
            check("es_door", door_open, 0);
            if (k == 0) check("es_pend4", pending[4], 1);
        end
        estop = 1'b0;
        tick();
        check("es_resume_motor", motor, 1);
        n = 1;
        while (cur_floor != 2 && n < 50) begin
            tick();
            n++;
        end
        check("es_arrive_ticks", n, 3);
        n = 0;
        while (!(door_open && cur_floor == 4) && n < 100) begin
            tick();
            n++;
        end
        check("es_serve4", int'(door_open && cur_floor == 4), 1);
`endif

        // randomized calls against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rv = ($urandom_range(0, 3) == 0);
            rf = $urandom_range(0, 7);
            drive(rv, rf);
            model_step(rv, rf);
            tick();
            drive(0, 0);
            exp_mot = (m_move > 0) ? ((m_step > 0) ? 1 : 2) : 0;
            check("rnd_motor", motor, exp_mot);
            check("rnd_door", door_open, int'(m_door > 0));
            check("rnd_floor", cur_floor, m_floor);
            check("rnd_pending", pending, int'(m_pend));
            check("rnd_busy", busy,
                  int'(m_move > 0 || m_door > 0 || m_pend != '0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
